// File: rtl/half_duplex_pkg.sv
// half_duplex_pkg: shared states and framing constants for half_duplex_link
package half_duplex_pkg;
  localparam int DATA_W = 8;
  localparam int FRAME_BITS = 10;
  typedef enum logic [2:0] {IDLE, TX, TURN, RX_START, RX_DATA, RX_STOP} state_t;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: self-reloading bit-period down-counter with full- and half-bit ticks
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic full,
  output logic half
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) cnt <= (rst || load || full) ? W'(CLKS_PER_BIT - 1) : cnt - 1'b1;
  assign full = cnt == '0;
  assign half = cnt == W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
endmodule

// File: rtl/half_duplex_link.sv
// half_duplex_link: single-wire UART-style link with transmit, turnaround and receive
module half_duplex_link
  import half_duplex_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TURN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              pad_t,
  output logic              pad_i,
  input  logic              pad_o
);
  state_t state, state_n;
  logic [1:0] sync;
  logic line, line_d, fall, transfer, full, half, tick;
  logic [7:0] bit_cnt;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  assign line = sync[1];
  assign fall = line_d & ~line;
  assign tx_ready = state == IDLE && !rst;
  assign transfer = tx_valid && tx_ready;
  assign tick = (state == TX || state == TURN) ? full : half;
  assign pad_t = state == TX;
  assign pad_i = pad_t ? tx_shift[0] : 1'b1;
  // Held loaded while idle so every frame, sent or received, starts a fresh bit period.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk (clk),
    .rst (rst),
    .load(state == IDLE),
    .full(full),
    .half(half)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = transfer ? TX : fall ? RX_START : IDLE;
      TX:       if (tick && bit_cnt == 8'(FRAME_BITS - 1)) state_n = TURN;
      TURN:     if (tick && bit_cnt == 8'(TURN_BITS - 1)) state_n = IDLE;
      RX_START: if (tick) state_n = line ? IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_cnt == 8'(DATA_W - 1)) state_n = RX_STOP;
      RX_STOP:  if (tick) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= 2'b11;
      line_d   <= 1'b1;
      bit_cnt  <= '0;
      tx_shift <= '1;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      sync    <= {sync[0], pad_o};
      line_d  <= line;
      bit_cnt <= (state_n != state) ? '0 : bit_cnt + 8'(tick);
      if (transfer) tx_shift <= {1'b1, tx_data, 1'b0};
      else if (state == TX && tick) tx_shift <= {1'b1, tx_shift[FRAME_BITS-1:1]};
      if (state == RX_DATA && tick) rx_shift <= {line, rx_shift[DATA_W-1:1]};
      if (state == RX_STOP && tick && line) rx_data <= rx_shift;
      rx_valid <= state == RX_STOP && tick && line;
      rx_err   <= state == RX_STOP && tick && !line;
    end
  end
endmodule

// File: doc/half_duplex_link.md
HALF_DUPLEX_LINK -- requirements
Module: half_duplex_link

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal minimum 4.
REQ-002 SHALL have parameter TURN_BITS, default 2, idle bit-times held released after each transmit before listening.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tx_data  input  8  byte to transmit.
REQ-006 SHALL have port tx_valid  input  1  tx_data is offered.
REQ-007 SHALL have port tx_ready  output  1  block accepts tx_data this cycle.
REQ-008 SHALL have port rx_data  output  8  last received byte.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse: rx_data is new and good.
REQ-010 SHALL have port rx_err  output  1  one-cycle pulse: framing error (stop bit low).
REQ-011 SHALL have port pad_t  output  1  pad drive enable; 1 drives line, 0 releases it (pulled high externally).
REQ-012 SHALL have port pad_i  output  1  value driven onto line when pad_t=1.
REQ-013 SHALL have port pad_o  input  1  line value read back from pad, asynchronous.

Function
REQ-014 SHALL frame bytes as start bit 0, 8 data bits LSB first, stop bit 1, each CLKS_PER_BIT cycles.
REQ-015 SHALL pass pad_o through a 2-flop synchronizer before any use.
REQ-016 SHALL implement states IDLE, TX, TURN, RX_START, RX_DATA, RX_STOP.
REQ-017 SHALL assert tx_ready only in IDLE; transfer occurs when tx_valid and tx_ready are high on the same edge.
REQ-018 SHALL, on transfer, latch tx_data, enter TX, and assert pad_t=1 with pad_i=0 on the following cycle.
REQ-019 SHALL in TX hold pad_t=1 for exactly 10*CLKS_PER_BIT cycles, pad_i following the frame bits.
REQ-020 SHALL after the stop bit enter TURN with pad_t=0 for TURN_BITS*CLKS_PER_BIT cycles, ignoring the line, then return to IDLE.
REQ-021 SHALL ignore the line (no receive) in TX and TURN; the block's own echo is never received.
REQ-022 SHALL in IDLE detect a start on synchronized line 1->0 and enter RX_START.
REQ-023 SHALL in RX_START resample at CLKS_PER_BIT/2 cycles; if high, return to IDLE with no pulse (false start); if low, enter RX_DATA.
REQ-024 SHALL sample 8 data bits at successive mid-bit points, spaced CLKS_PER_BIT cycles, shifting LSB first.
REQ-025 SHALL sample stop bit at mid-bit: high -> update rx_data and pulse rx_valid; low -> pulse rx_err with rx_data unchanged; either way return to IDLE the next cycle.
REQ-026 SHALL, when tx transfer and a start edge coincide in IDLE, give priority to transmit and discard the edge.
REQ-027 SHALL never assert rx_valid and rx_err in the same cycle; pad_t SHALL be 0 in every state except TX.

Reset
REQ-028 SHALL on rst=1 at a clock edge enter IDLE, outputs: pad_t=0, pad_i=1, tx_ready=0 during rst, rx_valid=0, rx_err=0, rx_data=8'h00, synchronizer flops=1.
REQ-029 SHALL when reset mid-frame (TX or RX) release the line on the next cycle, drop the partial byte, and emit no pulse.
REQ-030 SHALL assert tx_ready the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the state enum, frame length constant (10) and data width (8) in shared package half_duplex_pkg.
REQ-032 SHALL use one sub-module, bit_timer: loadable down-counter producing a tick at full-bit and half-bit terminal counts.

Verification (bench CLKS_PER_BIT=4, TURN_BITS=2)
REQ-033 SHALL check send 8'hA5 -> pad_t high 40 cycles, pad_i sequence 0,1,0,1,0,0,1,0,1,1 per 4 cycles, then 8 released cycles before tx_ready=1.
REQ-034 SHALL check external drive of 8'h3C with good stop -> single rx_valid pulse, rx_data=8'h3C.
REQ-035 SHALL check external frame 8'h55 with stop bit 0 -> rx_err pulse, rx_valid silent, rx_data unchanged.
REQ-036 SHALL check 1-cycle low glitch in IDLE -> return to IDLE, no pulses, tx_ready high again.
REQ-037 SHALL check rst asserted mid-TX at bit 4 -> pad_t=0 next cycle, no rx pulse, tx_ready=1 after release.
REQ-038 SHALL check tx_valid coincident with start edge -> transmit proceeds, no rx pulse.
